// File: rtl/vga_timing_gen.sv
// Free-running VGA scan timing: pixel-enable divider, h/v scan counters, sync/visible decode,
// and frame/move strobes for downstream object-position logic.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_START     = 144,
   parameter int unsigned H_END       = 784,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_START     = 35,
   parameter int unsigned V_END       = 515,
   parameter int unsigned MOVE_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       frame_tick,
   output logic       move_tick
);

   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FRAME_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MOVE_FRAMES - 1);
   localparam logic [9:0]         H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]         V_LAST     = 10'(V_TOTAL - 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [9:0]         h_q, h_d;
   logic [9:0]         v_q, v_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   logic div_last, h_last, v_last, frame_last;

   assign div_last   = (div_q == DIV_LAST);
   assign h_last     = (h_q == H_LAST);
   assign v_last     = (v_q == V_LAST);
   assign frame_last = (frame_q == FRAME_LAST);

   // Strobes are gated by rst so nothing fires on the edge that resets the counters.
   assign pix_en     = div_last && !rst;
   assign frame_tick = pix_en && h_last && v_last;
   assign move_tick  = frame_tick && frame_last;

   assign hCount = h_q;
   assign vCount = v_q;
   assign hSync  = (h_q >= 10'(H_SYNC));
   assign vSync  = (v_q >= 10'(V_SYNC));
   assign bright = (h_q >= 10'(H_START)) && (h_q < 10'(H_END)) &&
                   (v_q >= 10'(V_START)) && (v_q < 10'(V_END));

   always_comb begin
      div_d   = div_last ? '0 : div_q + DIV_W'(1);
      h_d     = h_q;
      v_d     = v_q;
      frame_d = frame_q;
      if (pix_en) begin
         if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      if (frame_tick) begin
         frame_d = frame_last ? '0 : frame_q + FRAME_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
      end
   end

endmodule
